// File: rtl/sha256_k_sequencer.sv
// ---------------------------------------------------------------------------
// sha256_k_sequencer
//
// Purpose:
//   Delivers the 64 SHA-256 round constants K[0..63] LANES at a time to an
//   unrolled compression core. A start/advance/abort handshake steps through
//   one 64-round run. The block reports the round index of lane 0, the final
//   step of the run and a one-cycle completion pulse.
//
// Handshake:
//   start is honoured only in IDLE. adv and abort are honoured only in RUN.
//   abort has priority over adv. While k_valid=1 the core owns the current
//   group. The core raises adv in the cycle it consumes that group, and the
//   next group appears after that clock edge. With adv held low, every output
//   holds its value.
//
// Parameters:
//   LANES     rounds consumed per step: 1, 2, 4 or 8.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset
//   start     in   begin a 64-round run (IDLE only)
//   adv       in   core consumed the current K group (RUN only)
//   abort     in   synchronous cancel of a run (RUN only)
//   k         out  K[round+i] for i=0..LANES-1; lane 0 is in the MSBs
//   k_valid   out  k is valid for the current step
//   round     out  round index of lane 0
//   last      out  current step is the final step of the run
//   busy      out  run in progress
//   done      out  one-cycle pulse after a run completes normally
//   k_next    out  (only with SHA256_K_LOOKAHEAD_EN) constants of the
//                  following step, packed the same way as k
//
// Configuration macro:
//   SHA256_K_LOOKAHEAD_EN  adds the k_next lookahead port.
// ---------------------------------------------------------------------------
module sha256_k_sequencer #(
   parameter int LANES = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  adv,
   input  logic                  abort,
   output logic [32*LANES-1:0]   k,
   output logic                  k_valid,
   output logic [5:0]            round,
   output logic                  last,
   output logic                  busy,
   output logic                  done
`ifdef SHA256_K_LOOKAHEAD_EN
   ,
   output logic [32*LANES-1:0]   k_next
`endif
);

   // LANES must divide 64 and be at most 8.
   if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
      $error("sha256_k_sequencer: LANES must be 1, 2, 4 or 8");
   end

   localparam logic [5:0] STEP       = 6'(LANES);
   localparam logic [5:0] LAST_ROUND = 6'(64 - LANES);

   localparam logic [31:0] K_ROM [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [5:0] round_q, round_d;
   logic       done_q,  done_d;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         round_q <= 6'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic. round_q stays 0 in IDLE, so k already shows K[0..]
   // before start arrives.
   always_comb begin
      state_d = state_q;
      round_d = round_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               round_d = 6'd0;
            end
         end
         S_RUN: begin
            if (abort) begin
               state_d = S_IDLE;
               round_d = 6'd0;
            end else if (adv) begin
               if (round_q == LAST_ROUND) begin
                  state_d = S_IDLE;
                  round_d = 6'd0;
                  done_d  = 1'b1;
               end else begin
                  round_d = round_q + STEP;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            round_d = 6'd0;
         end
      endcase
   end

   // Output decode. Everything here depends only on registered state.
   always_comb begin
      logic [5:0] idx;
      k_valid = (state_q == S_RUN);
      busy    = (state_q == S_RUN);
      last    = (state_q == S_RUN) && (round_q == LAST_ROUND);
      round   = round_q;
      done    = done_q;
      k       = '0;
      for (int i = 0; i < LANES; i++) begin
         idx = round_q + 6'(i);
         k[32*(LANES-i)-1 -: 32] = K_ROM[idx];
      end
   end

`ifdef SHA256_K_LOOKAHEAD_EN
   // The 6-bit sum wraps to 0 on the last step, which yields K[0..] there.
   // In IDLE round_q is 0, which yields K[LANES..].
   always_comb begin
      logic [5:0] nidx;
      k_next = '0;
      for (int i = 0; i < LANES; i++) begin
         nidx = round_q + STEP + 6'(i);
         k_next[32*(LANES-i)-1 -: 32] = K_ROM[nidx];
      end
   end
`endif

endmodule

// File: tb/tb_sha256_k_sequencer.sv
module tb_sha256_k_sequencer;

  localparam int W = 42;  // {k_valid, busy, last, done, round[5:0], k[31:0]}

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT, LANES=1 ----------------
  logic        start1, adv1, abort1;
  logic [31:0] k1;
  logic        kv1, last1, busy1, done1;
  logic [5:0]  round1;
`ifdef SHA256_K_LOOKAHEAD_EN
  logic [31:0] kn1;
`endif

  sha256_k_sequencer #(.LANES(1)) u_dut1 (
    .clk     (clk),
    .rst     (rst),
    .start   (start1),
    .adv     (adv1),
    .abort   (abort1),
    .k       (k1),
    .k_valid (kv1),
    .round   (round1),
    .last    (last1),
    .busy    (busy1),
    .done    (done1)
`ifdef SHA256_K_LOOKAHEAD_EN
    ,
    .k_next  (kn1)
`endif
  );

  // ---------------- DUT, LANES=2 ----------------
  logic        start2, adv2, abort2;
  logic [63:0] k2;
  logic        kv2, last2, busy2, done2;
  logic [5:0]  round2;
`ifdef SHA256_K_LOOKAHEAD_EN
  logic [63:0] kn2;
`endif

  sha256_k_sequencer #(.LANES(2)) u_dut2 (
    .clk     (clk),
    .rst     (rst),
    .start   (start2),
    .adv     (adv2),
    .abort   (abort2),
    .k       (k2),
    .k_valid (kv2),
    .round   (round2),
    .last    (last2),
    .busy    (busy2),
    .done    (done2)
`ifdef SHA256_K_LOOKAHEAD_EN
    ,
    .k_next  (kn2)
`endif
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int vcount = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] sb_got, sb_exp;

  // behavioural model state for u_dut1
  logic       m_run, m_done;
  logic [5:0] m_round;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation whenever u_dut1 presents valid output or done.
  always @(negedge clk) begin
    if (rst === 1'b1 && (kv1 === 1'b1 || done1 === 1'b1)) begin
      sb_got = {kv1, busy1, last1, done1, round1, k1};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got %h expected none", sb_got);
      end else begin
        sb_exp = exp_q.pop_front();
        if (sb_got !== sb_exp) begin
          errors++;
          $display("FAIL sb_step: got %h expected %h", sb_got, sb_exp);
        end
      end
    end
    if (kv1 === 1'b1) vcount++;
  end

  // ---------------- driver ----------------
  // Drive one cycle on u_dut1, advance the model, push the expected response.
  task automatic cyc(input logic s, input logic a, input logic ab);
    start1 = s;
    adv1   = a;
    abort1 = ab;
    @(posedge clk);
    #1;
    if (m_run) begin
      if (ab) begin
        m_run = 1'b0; m_round = 6'd0; m_done = 1'b0;
      end else if (a) begin
        if (m_round == 6'd63) begin
          m_run = 1'b0; m_round = 6'd0; m_done = 1'b1;
        end else begin
          m_round = m_round + 6'd1; m_done = 1'b0;
        end
      end else begin
        m_done = 1'b0;
      end
    end else begin
      m_done = 1'b0;
      if (s) begin
        m_run = 1'b1; m_round = 6'd0;
      end
    end
    if (m_run || m_done)
      exp_q.push_back({m_run, m_run, (m_run && m_round == 6'd63), m_done, m_round, KT[m_round]});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int v0;

  initial begin
    rst = 1'b0;
    start1 = 0; adv1 = 0; abort1 = 0;
    start2 = 0; adv2 = 0; abort2 = 0;
    m_run = 0; m_done = 0; m_round = 0;

    // reset state
    #12;
    chk("rst_kvalid", {63'd0, kv1}, 64'd0);
    chk("rst_busy",   {63'd0, busy1}, 64'd0);
    chk("rst_last",   {63'd0, last1}, 64'd0);
    chk("rst_done",   {63'd0, done1}, 64'd0);
    chk("rst_round",  {58'd0, round1}, 64'd0);
    chk("rst_k",      {32'd0, k1}, 64'h428a2f98);
    chk("rst_k2",     k2, 64'h428a2f98_71374491);
`ifdef SHA256_K_LOOKAHEAD_EN
    chk("rst_knext",  {32'd0, kn1}, 64'h71374491);
`endif
    rst = 1'b1;

    // full run, LANES=1, adv held high
    v0 = vcount;
    cyc(1, 0, 0);
    chk("run_first_k", {32'd0, k1}, 64'h428a2f98);
`ifdef SHA256_K_LOOKAHEAD_EN
    chk("knext_r0", {32'd0, kn1}, 64'h71374491);
`endif
    cyc(0, 1, 0);
    chk("run_second_k", {32'd0, k1}, 64'h71374491);
    repeat (62) cyc(0, 1, 0);
    chk("r63_round", {58'd0, round1}, 64'd63);
    chk("r63_last",  {63'd0, last1}, 64'd1);
    chk("r63_k",     {32'd0, k1}, 64'hc67178f2);
`ifdef SHA256_K_LOOKAHEAD_EN
    chk("knext_r63", {32'd0, kn1}, 64'h428a2f98);
`endif
    cyc(0, 1, 0);
    chk("end_done", {63'd0, done1}, 64'd1);
    chk("end_busy", {63'd0, busy1}, 64'd0);
    chk("end_k",    {32'd0, k1}, 64'h428a2f98);
    cyc(0, 1, 0);
    chk("end_done_drop", {63'd0, done1}, 64'd0);
    chk("end_no_wrap",   {63'd0, kv1}, 64'd0);
    chk("valid_steps", 64'(vcount - v0), 64'd64);

    // hold at round 10, start ignored in RUN
    cyc(1, 0, 0);
    repeat (10) cyc(0, 1, 0);
    repeat (5) cyc(0, 0, 0);
    chk("hold_k",     {32'd0, k1}, 64'h243185be);
    chk("hold_round", {58'd0, round1}, 64'd10);
    cyc(1, 0, 0);
    chk("start_in_run_round", {58'd0, round1}, 64'd10);
    cyc(0, 0, 1);
    chk("abort_idle", {63'd0, busy1}, 64'd0);

    // abort at round 20 with adv in the same cycle
    cyc(1, 0, 0);
    repeat (20) cyc(0, 1, 0);
    chk("pre_abort_round", {58'd0, round1}, 64'd20);
    cyc(0, 1, 1);
    chk("abort_busy",  {63'd0, busy1}, 64'd0);
    chk("abort_round", {58'd0, round1}, 64'd0);
    chk("abort_k",     {32'd0, k1}, 64'h428a2f98);
    chk("abort_done",  {63'd0, done1}, 64'd0);
    cyc(0, 0, 0);
    chk("abort_done_next", {63'd0, done1}, 64'd0);
    cyc(1, 0, 0);
    chk("restart_k",     {32'd0, k1}, 64'h428a2f98);
    chk("restart_valid", {63'd0, kv1}, 64'd1);

    // asynchronous reset mid-run at round 30
    repeat (30) cyc(0, 1, 0);
    chk("r30_k", {32'd0, k1}, 64'h06ca6351);
    adv1 = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_kvalid", {63'd0, kv1}, 64'd0);
    chk("arst_busy",   {63'd0, busy1}, 64'd0);
    chk("arst_last",   {63'd0, last1}, 64'd0);
    chk("arst_round",  {58'd0, round1}, 64'd0);
    chk("arst_k",      {32'd0, k1}, 64'h428a2f98);
    m_run = 0; m_done = 0; m_round = 0;
    start1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("arst_hold_kvalid", {63'd0, kv1}, 64'd0);
    start1 = 1'b0;
    #2;
    rst = 1'b1;
    cyc(0, 0, 0);
    chk("post_rst_idle", {63'd0, kv1}, 64'd0);
    cyc(1, 0, 0);
    chk("post_rst_start_round", {58'd0, round1}, 64'd0);
    chk("post_rst_start_k",     {32'd0, k1}, 64'h428a2f98);
    cyc(0, 0, 1);

    // LANES=2 run
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    chk("l2_first_k",     k2, 64'h428a2f98_71374491);
    chk("l2_first_valid", {63'd0, kv2}, 64'd1);
    adv2 = 1'b1;
    repeat (31) begin @(posedge clk); #1; end
    chk("l2_round62", {58'd0, round2}, 64'd62);
    chk("l2_last",    {63'd0, last2}, 64'd1);
    chk("l2_last_k",  k2, 64'hbef9a3f7_c67178f2);
    @(posedge clk); #1;
    adv2 = 1'b0;
    chk("l2_done", {63'd0, done2}, 64'd1);
    chk("l2_busy", {63'd0, busy2}, 64'd0);
    @(posedge clk); #1;
    chk("l2_done_drop", {63'd0, done2}, 64'd0);

    repeat (2) @(posedge clk);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
